// File: rtl/morra_pkg.sv
// Shared codes and types for the Morra Cinese game FSM and its result scoreboard.
package morra_pkg;

    localparam logic [1:0] ROUND_NONE = 2'b00;
    localparam logic [1:0] ROUND_P1   = 2'b01;
    localparam logic [1:0] ROUND_P2   = 2'b10;
    localparam logic [1:0] ROUND_DRAW = 2'b11;

    localparam logic [1:0] GAME_RUN = 2'b00;
    localparam logic [1:0] GAME_P1  = 2'b01;
    localparam logic [1:0] GAME_P2  = 2'b10;
    localparam logic [1:0] GAME_TIE = 2'b11;

    typedef enum logic {IDLE, PEND} res_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear together with an increment restarts the count at 1.
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? ONE : '0;
        end else if (inc && cnt_q != MAX) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/morra_scoreboard.sv
// Per-game round tallies, winning streak, session totals and a valid/ack result record.
module morra_scoreboard
    import morra_pkg::*;
#(
    parameter int CNT_W = 5,
    parameter int SES_W = 4
) (
    input  logic             clk,
    input  logic             START,
    input  logic [1:0]       ROUND,
    input  logic [1:0]       GAME,
    input  logic             RES_ACK,
    output logic [CNT_W-1:0] P1_ROUNDS,
    output logic [CNT_W-1:0] P2_ROUNDS,
    output logic [CNT_W-1:0] DRAWS,
    output logic [SES_W-1:0] STREAK,
    output logic [1:0]       STREAK_OWNER,
    output logic             RES_VALID,
    output logic [1:0]       RES_GAME,
    output logic [CNT_W-1:0] RES_P1,
    output logic [CNT_W-1:0] RES_P2,
    output logic [CNT_W-1:0] RES_DRAWS,
    output logic [SES_W-1:0] RES_MAX_STREAK,
    output logic             OVERRUN,
    output logic [SES_W-1:0] WINS_P1,
    output logic [SES_W-1:0] WINS_P2,
    output logic [SES_W-1:0] TIES
);

    localparam logic [SES_W-1:0] S_MAX = '1;
    localparam logic [SES_W-1:0] S_ONE = {{(SES_W-1){1'b0}}, 1'b1};

    logic             game_end, p1_win, p2_win, draw, win, new_owner;
    logic [1:0]       winner;
    logic [SES_W-1:0] streak_nxt;

    logic [1:0]       owner_q;
    logic [SES_W-1:0] max_q;
    res_state_t       state_q;
    logic             valid_q, overrun_q;
    logic [1:0]       rgame_q;
    logic [CNT_W-1:0] rp1_q, rp2_q, rdraws_q;
    logic [SES_W-1:0] rmax_q;

    // Rounds only count while the game is running; an ending cycle ignores ROUND.
    assign game_end  = (GAME != GAME_RUN);
    assign p1_win    = !game_end && (ROUND == ROUND_P1);
    assign p2_win    = !game_end && (ROUND == ROUND_P2);
    assign draw      = !game_end && (ROUND == ROUND_DRAW);
    assign win       = p1_win || p2_win;
    assign winner    = p1_win ? ROUND_P1 : ROUND_P2;
    assign new_owner = win && (owner_q != winner);

    sat_counter #(.WIDTH(CNT_W)) u_p1 (.clk(clk), .rst(START), .clr(game_end), .inc(p1_win), .cnt(P1_ROUNDS));
    sat_counter #(.WIDTH(CNT_W)) u_p2 (.clk(clk), .rst(START), .clr(game_end), .inc(p2_win), .cnt(P2_ROUNDS));
    sat_counter #(.WIDTH(CNT_W)) u_dr (.clk(clk), .rst(START), .clr(game_end), .inc(draw),   .cnt(DRAWS));

    sat_counter #(.WIDTH(SES_W)) u_stk (.clk(clk), .rst(START), .clr(game_end || draw || new_owner),
                                        .inc(win), .cnt(STREAK));

    sat_counter #(.WIDTH(SES_W)) u_w1 (.clk(clk), .rst(START), .clr(1'b0), .inc(GAME == GAME_P1),  .cnt(WINS_P1));
    sat_counter #(.WIDTH(SES_W)) u_w2 (.clk(clk), .rst(START), .clr(1'b0), .inc(GAME == GAME_P2),  .cnt(WINS_P2));
    sat_counter #(.WIDTH(SES_W)) u_ti (.clk(clk), .rst(START), .clr(1'b0), .inc(GAME == GAME_TIE), .cnt(TIES));

    // Mirror of the streak counter's next value, so the max tracks it on the same edge.
    always_comb begin
        streak_nxt = STREAK;
        if (game_end || draw) begin
            streak_nxt = '0;
        end else if (new_owner) begin
            streak_nxt = S_ONE;
        end else if (win && STREAK != S_MAX) begin
            streak_nxt = STREAK + S_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (START || game_end) begin
            owner_q <= 2'b00;
            max_q   <= '0;
        end else begin
            if (draw) begin
                owner_q <= 2'b00;
            end else if (win) begin
                owner_q <= winner;
            end
            if (streak_nxt > max_q) begin
                max_q <= streak_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (START) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            rgame_q   <= 2'b00;
            rp1_q     <= '0;
            rp2_q     <= '0;
            rdraws_q  <= '0;
            rmax_q    <= '0;
        end else begin
            if (game_end) begin
                rgame_q  <= GAME;
                rp1_q    <= P1_ROUNDS;
                rp2_q    <= P2_ROUNDS;
                rdraws_q <= DRAWS;
                rmax_q   <= max_q;
            end
            case (state_q)
                IDLE: begin
                    if (game_end) begin
                        state_q <= PEND;
                        valid_q <= 1'b1;
                    end
                end
                PEND: begin
                    if (game_end) begin
                        if (!RES_ACK) overrun_q <= 1'b1;
                    end else if (RES_ACK) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign STREAK_OWNER   = owner_q;
    assign RES_VALID      = valid_q;
    assign RES_GAME       = rgame_q;
    assign RES_P1         = rp1_q;
    assign RES_P2         = rp2_q;
    assign RES_DRAWS      = rdraws_q;
    assign RES_MAX_STREAK = rmax_q;
    assign OVERRUN        = overrun_q;

endmodule

// File: tb/tb_morra_scoreboard.sv
// Directed scoreboard bench for morra_scoreboard: stimulus queues expected field values, a monitor checks them.
module tb_morra_scoreboard;

    localparam int CNT_W = 5;
    localparam int SES_W = 4;

    typedef enum int {F_P1, F_P2, F_DR, F_STK, F_OWN, F_VLD, F_RG, F_RP1, F_RP2,
                      F_RDR, F_RMX, F_OVR, F_W1, F_W2, F_TI} field_t;

    typedef struct {
        int     cyc;
        field_t fld;
        int     exp;
    } exp_t;

    logic             clk = 1'b0;
    logic             START = 1'b0;
    logic [1:0]       ROUND = 2'b00;
    logic [1:0]       GAME = 2'b00;
    logic             RES_ACK = 1'b0;
    logic [CNT_W-1:0] P1_ROUNDS, P2_ROUNDS, DRAWS, RES_P1, RES_P2, RES_DRAWS;
    logic [SES_W-1:0] STREAK, RES_MAX_STREAK, WINS_P1, WINS_P2, TIES;
    logic [1:0]       STREAK_OWNER, RES_GAME;
    logic             RES_VALID, OVERRUN;

    morra_scoreboard #(.CNT_W(CNT_W), .SES_W(SES_W)) dut (
        .clk(clk), .START(START), .ROUND(ROUND), .GAME(GAME), .RES_ACK(RES_ACK),
        .P1_ROUNDS(P1_ROUNDS), .P2_ROUNDS(P2_ROUNDS), .DRAWS(DRAWS),
        .STREAK(STREAK), .STREAK_OWNER(STREAK_OWNER),
        .RES_VALID(RES_VALID), .RES_GAME(RES_GAME), .RES_P1(RES_P1), .RES_P2(RES_P2),
        .RES_DRAWS(RES_DRAWS), .RES_MAX_STREAK(RES_MAX_STREAK), .OVERRUN(OVERRUN),
        .WINS_P1(WINS_P1), .WINS_P2(WINS_P2), .TIES(TIES)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_field(field_t f);
        case (f)
            F_P1:    return int'(P1_ROUNDS);
            F_P2:    return int'(P2_ROUNDS);
            F_DR:    return int'(DRAWS);
            F_STK:   return int'(STREAK);
            F_OWN:   return int'(STREAK_OWNER);
            F_VLD:   return int'(RES_VALID);
            F_RG:    return int'(RES_GAME);
            F_RP1:   return int'(RES_P1);
            F_RP2:   return int'(RES_P2);
            F_RDR:   return int'(RES_DRAWS);
            F_RMX:   return int'(RES_MAX_STREAK);
            F_OVR:   return int'(OVERRUN);
            F_W1:    return int'(WINS_P1);
            F_W2:    return int'(WINS_P2);
            F_TI:    return int'(TIES);
            default: return -1;
        endcase
    endfunction

    // Monitor: on each falling edge, check every expectation stamped for this cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            int   act;
            e   = sbq.pop_front();
            act = get_field(e.fld);
            vectors++;
            if (e.cyc != cyc || act != e.exp) begin
                miscompares++;
                $display("FAIL %s cyc=%0d (stamp %0d): got %0d, expected %0d",
                         e.fld.name(), cyc, e.cyc, act, e.exp);
            end
        end
    end

    task automatic step(input logic st, input logic [1:0] r, input logic [1:0] g, input logic ack);
        START   = st;
        ROUND   = r;
        GAME    = g;
        RES_ACK = ack;
        @(posedge clk);
        #1;
        START   = 1'b0;
        ROUND   = 2'b00;
        GAME    = 2'b00;
        RES_ACK = 1'b0;
    endtask

    task automatic expect_f(input field_t f, input int v);
        exp_t e;
        e.cyc = cyc;
        e.fld = f;
        e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic expect_all_zero();
        for (int i = 0; i <= int'(F_TI); i++) expect_f(field_t'(i), 0);
    endtask

    initial begin
        // Reset
        step(1, 2'b01, 2'b01, 1);
        expect_all_zero();

        // Mixed rounds: 01,01,10,11,01
        step(0, 2'b01, 2'b00, 0);
        step(0, 2'b01, 2'b00, 0);
        expect_f(F_STK, 2); expect_f(F_OWN, 1);
        step(0, 2'b10, 2'b00, 0);
        expect_f(F_STK, 1); expect_f(F_OWN, 2);
        step(0, 2'b11, 2'b00, 0);
        expect_f(F_STK, 0); expect_f(F_OWN, 0);
        step(0, 2'b01, 2'b00, 0);
        expect_f(F_P1, 3); expect_f(F_P2, 1); expect_f(F_DR, 1);
        expect_f(F_STK, 1); expect_f(F_OWN, 1);
        step(0, 2'b00, 2'b01, 0);
        expect_f(F_VLD, 1); expect_f(F_RG, 1); expect_f(F_RP1, 3); expect_f(F_RP2, 1);
        expect_f(F_RDR, 1); expect_f(F_RMX, 2); expect_f(F_W1, 1);
        expect_f(F_P1, 0); expect_f(F_STK, 0); expect_f(F_OWN, 0);
        step(0, 2'b00, 2'b00, 1);
        expect_f(F_VLD, 0); expect_f(F_OVR, 0);
        step(0, 2'b00, 2'b00, 1);
        expect_f(F_VLD, 0);

        // P1 wins 3, void, end (ROUND ignored on the ending cycle)
        step(0, 2'b01, 2'b00, 0);
        step(0, 2'b01, 2'b00, 0);
        step(0, 2'b01, 2'b00, 0);
        step(0, 2'b00, 2'b00, 0);
        expect_f(F_STK, 3); expect_f(F_P1, 3);
        step(0, 2'b01, 2'b01, 0);
        expect_f(F_VLD, 1); expect_f(F_RP1, 3); expect_f(F_RP2, 0); expect_f(F_RMX, 3);
        expect_f(F_W1, 2); expect_f(F_P1, 0); expect_f(F_P2, 0); expect_f(F_DR, 0);

        // Second end without ack: overwrite + overrun
        step(0, 2'b10, 2'b00, 0);
        expect_f(F_P2, 1); expect_f(F_OWN, 2); expect_f(F_VLD, 1); expect_f(F_RP1, 3);
        step(0, 2'b00, 2'b10, 0);
        expect_f(F_VLD, 1); expect_f(F_RG, 2); expect_f(F_RP1, 0); expect_f(F_RP2, 1);
        expect_f(F_RMX, 1); expect_f(F_OVR, 1); expect_f(F_W2, 1);
        step(0, 2'b00, 2'b00, 1);
        expect_f(F_VLD, 0); expect_f(F_OVR, 1);

        // End together with ack while pending: no overrun
        step(1, 2'b00, 2'b00, 0);
        expect_all_zero();
        step(0, 2'b11, 2'b00, 0);
        step(0, 2'b00, 2'b11, 0);
        expect_f(F_VLD, 1); expect_f(F_RG, 3); expect_f(F_RDR, 1); expect_f(F_TI, 1);
        step(0, 2'b11, 2'b00, 0);
        step(0, 2'b11, 2'b00, 0);
        step(0, 2'b00, 2'b11, 1);
        expect_f(F_VLD, 1); expect_f(F_RDR, 2); expect_f(F_OVR, 0); expect_f(F_TI, 2);
        step(0, 2'b00, 2'b00, 1);
        expect_f(F_VLD, 0); expect_f(F_OVR, 0);

        // Saturation: 40 P1 rounds, then 17 ties
        for (int i = 0; i < 40; i++) step(0, 2'b01, 2'b00, 0);
        expect_f(F_P1, 31); expect_f(F_STK, 15); expect_f(F_OWN, 1);
        step(0, 2'b00, 2'b01, 0);
        expect_f(F_VLD, 1); expect_f(F_RP1, 31); expect_f(F_RMX, 15); expect_f(F_W1, 1);
        for (int i = 0; i < 17; i++) step(0, 2'b00, 2'b11, 0);
        expect_f(F_TI, 15); expect_f(F_OVR, 1); expect_f(F_RG, 3); expect_f(F_RP1, 0);
        expect_f(F_W1, 1);

        // START while pending with live tallies
        step(1, 2'b00, 2'b00, 0);
        expect_all_zero();
        step(0, 2'b01, 2'b00, 0);
        step(0, 2'b10, 2'b00, 0);
        step(0, 2'b00, 2'b01, 0);
        expect_f(F_VLD, 1); expect_f(F_RP1, 1); expect_f(F_RP2, 1); expect_f(F_RMX, 1);
        expect_f(F_W1, 1);
        step(0, 2'b01, 2'b00, 0);
        step(0, 2'b11, 2'b00, 0);
        expect_f(F_P1, 1); expect_f(F_DR, 1);
        step(1, 2'b01, 2'b00, 0);
        expect_all_zero();
        step(0, 2'b00, 2'b00, 1);
        expect_all_zero();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/morra_scoreboard.md
# morra_scoreboard

Downstream consumer of the Morra Cinese game FSM. Samples the per-cycle `ROUND` and `GAME` result codes and keeps per-game round tallies and a winning-streak tracker. When a game ends, it latches a result record and presents it to a display/host stage through a valid/ack handshake. It also keeps session-wide game totals, which clear only on reset.

## Interface
Parameters:
- `CNT_W`, 5: width of per-game round counters; saturate at 2^CNT_W-1.
- `SES_W`, 4: width of session game counters and streak counters; saturate at 2^SES_W-1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `START`  in  1  reset, synchronous and active-high; clears all state.
- `ROUND`  in  2  round code from game FSM: 00 none/void, 01 P1, 10 P2, 11 draw.
- `GAME`  in  2  game code from game FSM: 00 in progress, 01 P1, 10 P2, 11 tie.
- `RES_ACK`  in  1  downstream accepts the held result record.
- `P1_ROUNDS`, `P2_ROUNDS`, `DRAWS`  out  CNT_W  live per-game tallies.
- `STREAK`  out  SES_W  current consecutive-win count.
- `STREAK_OWNER`  out  2  01 P1, 10 P2, 00 none.
- `RES_VALID`  out  1  result record held and pending.
- `RES_GAME`  out  2  latched final `GAME` code.
- `RES_P1`, `RES_P2`, `RES_DRAWS`  out  CNT_W  latched final tallies.
- `RES_MAX_STREAK`  out  SES_W  longest streak of the finished game.
- `OVERRUN`  out  1  sticky; a record was overwritten before ack.
- `WINS_P1`, `WINS_P2`, `TIES`  out  SES_W  session totals.

## Operation
- All outputs are registered. On `START`=1, every output is 0, the FSM goes to IDLE, and all inputs are ignored that cycle.
- Round sampling, only when `GAME`=00:
  - `ROUND`=01: increment `P1_ROUNDS`.
  - `ROUND`=10: increment `P2_ROUNDS`.
  - `ROUND`=11: increment `DRAWS`.
  - `ROUND`=00: no change (idle or void round).
- Streak rules:
  - Win by the current owner: `STREAK`+1.
  - Win by the other player: owner changes, `STREAK`=1.
  - Draw: `STREAK`=0, owner 00.
  - Void: unchanged.
  - The per-game max streak is updated in the same cycle, as max(old max, new streak).
- Game end, when `GAME`≠00:
  - `ROUND` is ignored that cycle.
  - Result record loads: `RES_GAME`=`GAME`, tallies and max streak taken from current register values.
  - Per-game counters, streak, owner and max all clear to 0 on the same edge.
  - The session counter selected by `GAME` (01→`WINS_P1`, 10→`WINS_P2`, 11→`TIES`) increments.
- Handshake FSM:
  - IDLE: `RES_VALID`=0. On a game end, go to PEND.
  - PEND: `RES_VALID`=1 and the record is held stable. `RES_ACK`=1 with no game end → IDLE.
  - Game end in PEND, with or without ack in the same cycle: the record is overwritten and the FSM stays in PEND. `OVERRUN` is set only if `RES_ACK`=0.
  - `RES_ACK` in IDLE is ignored.
- Arithmetic: all counters saturate; no wrap. Tally comparisons are unsigned.
- `OVERRUN` clears only on `START`.

## Timing
- Latency is 1 cycle: a code sampled at edge k is visible on the outputs after edge k.
- `RES_VALID` rises 1 cycle after the `GAME`≠00 sample. Live tallies read 0 in that same cycle.
- `RES_ACK` sampled high at edge k drops `RES_VALID` after edge k.
- A game end at edge k followed by a round at edge k+1 gives fresh tallies starting from 0. No cycle is lost between games.
- `START` mid-game or while in PEND: all state clears at that edge, with no partial record.

## Structure
- Shared package `morra_pkg` holds:
  - round code constants `ROUND_NONE`/`ROUND_P1`/`ROUND_P2`/`ROUND_DRAW`;
  - game code constants `GAME_RUN`/`GAME_P1`/`GAME_P2`/`GAME_TIE`;
  - the `res_state_t` enum {IDLE, PEND}.
- Sub-module `sat_counter` (parameter WIDTH; inputs clr, inc) is instantiated for every tally, session and streak counter.
- The top level holds the streak logic, the record register and the handshake FSM.

## Test plan
- `START` then `ROUND` 01,01,10,11,01 with `GAME`=00 → `P1_ROUNDS`=3, `P2_ROUNDS`=1, `DRAWS`=1, `STREAK`=1, `STREAK_OWNER`=01.
- P1 wins 3 rounds, then a void, then `GAME`=01 → `RES_VALID`=1, `RES_P1`=3, `RES_MAX_STREAK`=3, `WINS_P1`=1, live tallies 0.
- Game ends twice with no ack → record shows the second game, `OVERRUN`=1. Then `RES_ACK` → `RES_VALID`=0, `OVERRUN` stays 1.
- Game end and `RES_ACK` in the same cycle while in PEND → new record, `RES_VALID` stays 1, `OVERRUN`=0.
- 40 consecutive `ROUND`=01 → `P1_ROUNDS`=31, `STREAK`=15 (saturated). 17 `GAME`=11 ends → `TIES`=15.
- `START` asserted while in PEND with nonzero tallies → all outputs 0 next cycle, and `RES_ACK` then has no effect.
